// File: rtl/rhythm_lane_engine.sv
// rhythm_lane_engine: N-lane note engine that scrolls lane windows, judges strikes and keeps a saturating score.
// Define GV_COMBO_EN to add a hit-streak bonus (+2 per hit once 8 consecutive hits are banked).
module rhythm_lane_engine #(
  parameter int LANES    = 2,
  parameter int SONG_LEN = 32,
  parameter int VIS      = 7,
  parameter int BEAT_W   = 23,
  parameter int SCORE_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      pause_i,
  input  logic                      quit_i,
  input  logic [BEAT_W-1:0]         beat_period_i,
  input  logic [LANES*SONG_LEN-1:0] song_i,
  input  logic [LANES-1:0]          btn_i,
  output logic [LANES*VIS-1:0]      window_o,
  output logic                      hit_o,
  output logic                      missed_o,
  output logic [SCORE_W-1:0]        score_o,
  output logic [SCORE_W-1:0]        num_hits_o,
  output logic [SCORE_W-1:0]        num_misses_o,
  output logic [1:0]                state_o,
  output logic                      beat_o
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, FINISH} state_t;
  localparam int END = SONG_LEN + VIS;
  localparam int PW  = $clog2(END + 1);
  localparam int CW  = $clog2(LANES + 1);
  localparam int EW  = SCORE_W + CW + 2;
  localparam logic signed [EW-1:0] SMAX = EW'((1 << (SCORE_W - 1)) - 1);
  localparam logic signed [EW-1:0] SMIN = ~SMAX;
  state_t                    state_q, state_d;
  logic [LANES*SONG_LEN-1:0] song_q;
  logic [BEAT_W-1:0]         period_q, cnt_q;
  logic [PW-1:0]             pos_q;
  logic [LANES*VIS-1:0]      win_q, win_d;
  logic [LANES-1:0]          btn_q, rise;
  logic signed [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0]        hits_q, hits_d, miss_q, miss_d;
  logic                      hit_q, missed_q, beat_q;
  logic                      run, upd, beat_now, fin;
  logic [CW-1:0]             nh, nm;
  logic [VIS-1:0]            lane;
  logic [EW-1:0]             pts;
  logic signed [EW-1:0]      ssum;
  logic [SCORE_W+CW-1:0]     hsum, msum;
  assign run      = state_q == RUN;
  assign upd      = run && !quit_i && !start_i;
  assign rise     = btn_i & ~btn_q;
  assign beat_now = run && cnt_q == (period_q == '0 ? '0 : period_q - 1'b1);
  assign fin      = beat_now && pos_q >= PW'(END - 1);
  // Strikes are judged on the pre-shift window, so a struck note is cleared before it can expire.
  always_comb begin
    win_d = win_q;
    nh = '0;
    nm = '0;
    lane = '0;
    for (int l = 0; l < LANES; l++) begin
      lane = win_q[l*VIS +: VIS];
      if (run && rise[l]) begin
        nh = nh + CW'(lane[0]);
        nm = nm + CW'(!lane[0]);
        lane[0] = 1'b0;
      end
      if (beat_now) begin
        nm = nm + CW'(lane[0]);
        lane = {|(song_q[l*SONG_LEN +: SONG_LEN] & (SONG_LEN'(1) << pos_q)), lane[VIS-1:1]};
      end
      win_d[l*VIS +: VIS] = lane;
    end
  end
`ifdef GV_COMBO_EN
  logic [3:0]    streak_q, streak_d;
  logic [CW+3:0] stk_sum;
  assign stk_sum  = (CW+4)'(streak_q) + (CW+4)'(nh);
  assign streak_d = |nm ? 4'd0 : |stk_sum[CW+3:4] ? 4'hF : stk_sum[3:0];
  assign pts      = streak_q >= 4'd8 ? EW'(nh) << 1 : EW'(nh);
  always_ff @(posedge clk or posedge rst)
    if (rst) streak_q <= '0;
    else if (start_i && !quit_i) streak_q <= '0;
    else if (upd) streak_q <= streak_d;
`else
  assign pts = EW'(nh);
`endif
  assign ssum    = $signed({{(EW-SCORE_W){score_q[SCORE_W-1]}}, score_q}) + $signed(pts) - $signed(EW'(nm));
  assign score_d = ssum > SMAX ? SMAX[SCORE_W-1:0] : ssum < SMIN ? SMIN[SCORE_W-1:0] : ssum[SCORE_W-1:0];
  assign hsum    = (SCORE_W+CW)'(hits_q) + (SCORE_W+CW)'(nh);
  assign msum    = (SCORE_W+CW)'(miss_q) + (SCORE_W+CW)'(nm);
  assign hits_d  = |hsum[SCORE_W+CW-1:SCORE_W] ? '1 : hsum[SCORE_W-1:0];
  assign miss_d  = |msum[SCORE_W+CW-1:SCORE_W] ? '1 : msum[SCORE_W-1:0];
  always_comb
    state_d = quit_i ? IDLE : start_i ? RUN : (run && pause_i) ? PAUSE : fin ? FINISH :
              (state_q == PAUSE && pause_i) ? RUN : state_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      song_q   <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      pos_q    <= '0;
      win_q    <= '0;
      btn_q    <= '0;
      score_q  <= '0;
      hits_q   <= '0;
      miss_q   <= '0;
      hit_q    <= 1'b0;
      missed_q <= 1'b0;
      beat_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      btn_q    <= btn_i;
      hit_q    <= upd && |nh;
      missed_q <= upd && |nm;
      beat_q   <= upd && beat_now;
      if (quit_i) win_q <= '0;
      else if (start_i) begin
        song_q   <= song_i;
        period_q <= beat_period_i;
        cnt_q    <= '0;
        pos_q    <= '0;
        win_q    <= '0;
        score_q  <= '0;
        hits_q   <= '0;
        miss_q   <= '0;
      end else if (run) begin
        cnt_q   <= beat_now ? '0 : cnt_q + 1'b1;
        win_q   <= win_d;
        score_q <= score_d;
        hits_q  <= hits_d;
        miss_q  <= miss_d;
        if (beat_now && pos_q != PW'(END)) pos_q <= pos_q + 1'b1;
      end
    end
  assign window_o     = win_q;
  assign hit_o        = hit_q;
  assign missed_o     = missed_q;
  assign score_o      = score_q;
  assign num_hits_o   = hits_q;
  assign num_misses_o = miss_q;
  assign state_o      = state_q;
  assign beat_o       = beat_q;
endmodule

// File: tb/tb_rhythm_lane_engine.sv
// tb_rhythm_lane_engine: directed checks of scrolling, strikes, saturation, pause and reset.
module tb_rhythm_lane_engine;
  logic        clk = 1'b0, rst = 1'b1, start_i = 1'b0, pause_i = 1'b0, quit_i = 1'b0;
  logic [22:0] beat_period_i = '0;
  logic [63:0] song_i = '0;
  logic [1:0]  btn_i = '0;
  logic [13:0] window_o;
  logic        hit_o, missed_o, beat_o;
  logic [7:0]  score_o, num_hits_o, num_misses_o;
  logic [1:0]  state_o;
  int          checks = 0, errors = 0;
  int          beats, n, exp_score;
  always #5 clk = ~clk;
  rhythm_lane_engine dut (
    .clk(clk), .rst(rst), .start_i(start_i), .pause_i(pause_i), .quit_i(quit_i),
    .beat_period_i(beat_period_i), .song_i(song_i), .btn_i(btn_i), .window_o(window_o),
    .hit_o(hit_o), .missed_o(missed_o), .score_o(score_o), .num_hits_o(num_hits_o),
    .num_misses_o(num_misses_o), .state_o(state_o), .beat_o(beat_o)
  );
  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic [22:0] p, input logic [63:0] s);
    beat_period_i = p;
    song_i = s;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask
  task automatic quit();
    quit_i = 1'b1;
    tick();
    quit_i = 1'b0;
  endtask
  task automatic wait_beat();
    int k = 0;
    do begin
      tick();
      k++;
    end while (!beat_o && k < 5000);
    check("beat_timeout", beat_o, 1);
  endtask
  initial begin
    tick(2);
    check("rst_state", state_o, 0);
    check("rst_window", window_o, 0);
    check("rst_score", score_o, 0);
    check("rst_counts", {num_hits_o, num_misses_o}, 0);
    check("rst_pulses", {hit_o, missed_o, beat_o}, 0);
    rst = 1'b0;
    tick();
    // single note hit on lane 0, period 4
    start(23'd4, {32'h0, 32'h1});
    check("t1_state", state_o, 1);
    tick(3);
    check("t1_nobeat", beat_o, 0);
    tick();
    check("t1_beat", beat_o, 1);
    check("t1_win_load", window_o, 14'h0040);
    repeat (6) wait_beat();
    check("t1_win_at0", window_o, 14'h0001);
    btn_i = 2'b01;
    tick();
    check("t1_hit", {hit_o, missed_o}, 2'b10);
    check("t1_score", score_o, 8'd1);
    check("t1_hits", num_hits_o, 8'd1);
    check("t1_win_clr", window_o, 14'h0000);
    tick();
    check("t1_held_btn", hit_o, 0);
    btn_i = 2'b00;
    quit();
    check("quit_state", state_o, 0);
    check("quit_score_kept", score_o, 8'd1);
    // lane 1 expiries to FINISH with period 0 (one beat per cycle)
    start(23'd0, {32'h8000_0021, 32'h0});
    check("t2_start_clr", {score_o, num_hits_o}, 0);
    beats = 0;
    n = 0;
    do begin
      tick();
      beats += int'(beat_o);
      n++;
    end while (state_o != 2'd3 && n < 500);
    check("t2_finish", state_o, 3);
    check("t2_beats", beats, 39);
    check("t2_misses", num_misses_o, 8'd3);
    check("t2_score", score_o, 8'hFD);
    check("t2_hits", num_hits_o, 8'd0);
    btn_i = 2'b11;
    tick();
    btn_i = 2'b00;
    tick(3);
    check("t2_finish_hold", {state_o, score_o, num_misses_o}, {2'd3, 8'hFD, 8'd3});
    check("t2_finish_nobeat", beat_o, 0);
    // simultaneous two-lane strike coinciding with a beat
    start(23'd2, {32'h0, 32'h1});
    check("t3_restart", {state_o, score_o, num_misses_o}, {2'd1, 8'd0, 8'd0});
    repeat (7) wait_beat();
    check("t3_win_at0", window_o, 14'h0001);
    tick();
    btn_i = 2'b11;
    tick();
    btn_i = 2'b00;
    check("t3_pulses", {hit_o, missed_o, beat_o}, 3'b111);
    check("t3_score", score_o, 8'd0);
    check("t3_counts", {num_hits_o, num_misses_o}, {8'd1, 8'd1});
    check("t3_win", window_o, 14'h0000);
    // negative saturation with no beats
    quit();
    start(23'd100000, 64'h0);
    btn_i = 2'b11;
    tick();
    btn_i = 2'b00;
    check("t4_first", {missed_o, score_o, num_misses_o}, {1'b1, 8'hFE, 8'd2});
    tick();
    repeat (63) begin
      btn_i = 2'b11;
      tick();
      btn_i = 2'b00;
      tick();
    end
    check("t4_at_min", {score_o, num_misses_o}, {8'h80, 8'd128});
    repeat (36) begin
      btn_i = 2'b11;
      tick();
      btn_i = 2'b00;
      tick();
    end
    check("t4_sat_score", score_o, 8'h80);
    check("t4_misses", num_misses_o, 8'd200);
    #3 rst = 1'b1;
    #1;
    check("t4_async_rst", {state_o, score_o, num_misses_o, num_hits_o}, 0);
    check("t4_async_rst_win", window_o, 0);
    tick();
    rst = 1'b0;
    tick();
    // pause freezes the beat counter mid-period
    start(23'd4, {32'h0, 32'hFF});
    wait_beat();
    wait_beat();
    check("t5_win", window_o, 14'h0060);
    tick(2);
    pause_i = 1'b1;
    tick();
    pause_i = 1'b0;
    check("t5_paused", state_o, 2);
    beats = 0;
    repeat (50) begin
      tick();
      beats += int'(beat_o);
    end
    check("t5_nobeats", beats, 0);
    check("t5_win_frozen", window_o, 14'h0060);
    pause_i = 1'b1;
    tick();
    pause_i = 1'b0;
    check("t5_resume", {state_o, beat_o}, {2'd1, 1'b0});
    tick();
    check("t5_beat_held_cnt", beat_o, 1);
    check("t5_win_next", window_o, 14'h0070);
    // ten consecutive hits, one miss, one hit
    quit();
    start(23'd4, {32'h0, 32'h13FF});
    repeat (7) wait_beat();
    for (int i = 0; i < 10; i++) begin
      btn_i = 2'b01;
      tick();
      btn_i = 2'b00;
      check("t6_hit", hit_o, 1);
      wait_beat();
    end
`ifdef GV_COMBO_EN
    exp_score = 12;
`else
    exp_score = 10;
`endif
    check("t6_streak_score", score_o, exp_score);
    check("t6_hits", num_hits_o, 8'd10);
    btn_i = 2'b01;
    tick();
    btn_i = 2'b00;
    check("t6_miss", {hit_o, missed_o}, 2'b01);
    check("t6_miss_score", score_o, exp_score - 1);
    wait_beat();
    wait_beat();
    check("t6_note12", window_o[0], 1);
    btn_i = 2'b01;
    tick();
    btn_i = 2'b00;
    check("t6_rehit_score", score_o, exp_score);
    check("t6_final_counts", {num_hits_o, num_misses_o}, {8'd11, 8'd1});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
